// File: rtl/lfsr_pkg.sv
// Shared LFSR types, default maximal-length tap masks and a single-step helper.
// The helper works on a 32-bit container; callers pass the real width.
package lfsr_pkg;

  typedef enum logic {
    LFSR_FIB = 1'b0,
    LFSR_GAL = 1'b1
  } lfsr_mode_e;

  localparam int unsigned LFSR_MAX_W = 32;

  localparam logic [3:0]  LFSR_TAPS_4  = 4'hC;
  localparam logic [7:0]  LFSR_TAPS_8  = 8'hB8;
  localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;
  localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;

  typedef struct packed {
    logic [LFSR_MAX_W-1:0] next;
    logic                  out_bit;
  } lfsr_step_t;

  function automatic lfsr_step_t lfsr_step(input logic [LFSR_MAX_W-1:0] state,
                                           input logic [LFSR_MAX_W-1:0] taps,
                                           input int unsigned           width,
                                           input lfsr_mode_e            mode);
    lfsr_step_t            res;
    logic [LFSR_MAX_W-1:0] mask;
    logic                  msb;
    mask = 32'hFFFF_FFFF >> (LFSR_MAX_W - width);
    msb  = |(state & (32'h1 << (width - 1)));
    if (mode == LFSR_FIB) begin
      res.out_bit = ^(state & taps & mask);
      res.next    = ((state << 1) | {31'd0, res.out_bit}) & mask;
    end else begin
      res.out_bit = msb;
      res.next    = ((state << 1) ^ (msb ? taps : '0)) & mask;
    end
    return res;
  endfunction

endpackage

// File: rtl/lfsr_step_comb.sv
// One combinational LFSR step; the top chains STEPS of these per clock.
module lfsr_step_comb
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = LFSR_TAPS_16,
  parameter lfsr_mode_e       MODE  = LFSR_FIB
) (
  input  logic [WIDTH-1:0] state_i,
  output logic [WIDTH-1:0] next_o,
  output logic             bit_o
);

  lfsr_step_t res;
  logic       unused_hi;

  always_comb begin
    res = lfsr_step(32'(state_i), 32'(TAPS), WIDTH, MODE);
  end

  assign next_o    = res.next[WIDTH-1:0];
  assign bit_o     = res.out_bit;
  // upper container bits are always masked to zero
  assign unused_hi = ^res.next;

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised LFSR generator: STEPS chained steps per enabled clock, runtime
// seed load with zero-seed recovery, per-advance output bits and wrap pulse.
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH  = 16,
  parameter logic [WIDTH-1:0] TAPS   = 16'hB400,
  parameter logic [WIDTH-1:0] SEED   = 16'h0001,
  parameter int               GALOIS = 0,
  parameter int               STEPS  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] seed_in_i,
  output logic [WIDTH-1:0] state_o,
  output logic [STEPS-1:0] bits_out_o,
  output logic             out_valid_o,
  output logic             wrap_o,
  output logic             lockup_o
);

  localparam lfsr_mode_e MODE = (GALOIS != 0) ? LFSR_GAL : LFSR_FIB;

  if (SEED == '0) begin : g_bad_seed
    $error("lfsr_gen: SEED must be non-zero");
  end
  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("lfsr_gen: WIDTH must be 2..32");
  end
  if (STEPS < 1 || STEPS > WIDTH) begin : g_bad_steps
    $error("lfsr_gen: STEPS must be 1..WIDTH");
  end

  logic [WIDTH-1:0] state_q, state_d;
  logic [STEPS-1:0] bits_q, bits_d;
  logic             valid_q, valid_d;
  logic             wrap_q, wrap_d;
  logic             lockup_q, lockup_d;

  logic [WIDTH-1:0] chain [STEPS+1];
  logic [STEPS-1:0] step_bits;
  logic [STEPS-1:0] seed_hit;

  assign chain[0] = state_q;

  for (genvar k = 0; k < STEPS; k++) begin : g_step
    lfsr_step_comb #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS),
      .MODE  (MODE)
    ) u_step (
      .state_i (chain[k]),
      .next_o  (chain[k+1]),
      .bit_o   (step_bits[k])
    );
    assign seed_hit[k] = (chain[k+1] == SEED);
  end

  always_comb begin
    state_d  = state_q;
    bits_d   = bits_q;
    valid_d  = 1'b0;
    wrap_d   = 1'b0;
    lockup_d = 1'b0;
    if (load_i) begin
      // a zero seed would freeze the register, so substitute SEED and flag it
      if (seed_in_i == '0) begin
        state_d  = SEED;
        lockup_d = 1'b1;
      end else begin
        state_d = seed_in_i;
      end
    end else if (en_i) begin
      state_d = chain[STEPS];
      bits_d  = step_bits;
      valid_d = 1'b1;
      wrap_d  = |seed_hit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SEED;
      bits_q   <= '0;
      valid_q  <= 1'b0;
      wrap_q   <= 1'b0;
      lockup_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      bits_q   <= bits_d;
      valid_q  <= valid_d;
      wrap_q   <= wrap_d;
      lockup_q <= lockup_d;
    end
  end

  assign state_o     = state_q;
  assign bits_out_o  = bits_q;
  assign out_valid_o = valid_q;
  assign wrap_o      = wrap_q;
  assign lockup_o    = lockup_q;

endmodule
